priority_encoder: RTL and testbench
===================================

Name: priority_encoder

Overview:
- 8-input to 3-bit priority encoder with a valid flag; the highest-numbered asserted input wins.
- Outputs are registered: one clock of latency, synchronous active-low reset.
- Used wherever a one-of-N request vector must be reduced to a binary index. Examples: interrupt or request arbitration front-ends, leading-one detection.

Parameters:
- REG_OUT, default 1, meaning:
  - 1 = outputs registered (1-cycle latency).
  - 0 = outputs purely combinational; clk and rst_n are unused.
  - Only the value 1 is required for sign-off.

Ports:
- clk    input   1  rising-edge clock
- rst_n  input   1  synchronous active-low reset
- y      input   8  request vector; bit 7 is highest priority, bit 0 lowest
- a      output  1  index bit 2 (MSB) of highest set bit of y
- b      output  1  index bit 1 of highest set bit of y
- c      output  1  index bit 0 (LSB) of highest set bit of y
- d      output  1  valid; 1 when any bit of y is set

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Combinational core:
  - idx = position of the most significant 1 in y.
  - {a,b,c} = idx.
  - d = OR-reduction of y.
- Priority is strictly by bit position. Lower set bits are ignored when any higher bit is set: y=8'b11000001 -> idx 7.
- No-request case: y == 0 -> {a,b,c}=3'b000, d=0. This index is a defined value, not a don't-care.
- y == 8'b00000001 -> {a,b,c}=000, d=1. Index 0 is distinguished from "no request" only by d.
- Registering (REG_OUT=1):
  - On each rising clk edge with rst_n=1, a,b,c,d capture the core result for the y present at that edge.
  - Latency is exactly 1 cycle.
  - Outputs hold between edges; y changes between edges have no effect until the next edge.
- Reset:
  - On a rising clk edge with rst_n=0: a=b=c=d=0, regardless of y.
  - rst_n asserted mid-operation clears the outputs at the next edge.
  - Outputs are unchanged until that edge, because reset is synchronous.
  - First edge with rst_n=1 after reset loads the encoding of the current y.
- Unknown or X inputs are not propagated deliberately. The bench drives only 0/1.
- No handshake and no state machine. Throughput is one new vector per cycle.

Decomposition:
- Shared package priority_encoder_pkg holds:
  - IN_W = 8
  - IDX_W = 3
  - Typedef idx_t, logic [IDX_W-1:0]
- Sub-module priority_encoder_core:
  - Purely combinational.
  - y[7:0] -> idx[2:0], valid.
  - Implemented as a downward scan loop or a casez priority chain.
- The top priority_encoder instantiates the core and adds the output register stage (or a bypass when REG_OUT=0).

Test Plan:
- Reset: hold rst_n=0 for 2 edges with y=8'hFF -> a,b,c,d = 0,0,0,0. Release rst_n with y=0 -> still 0000 after next edge.
- Single/low-bit walk, y applied one cycle before the check:
  - y=00000000 -> abc=000, d=0
  - y=00000001 -> abc=000, d=1
  - y=00000011 -> abc=001, d=1
  - y=00000101 -> abc=010, d=1
- Multi-bit with bit 0 always set:
  - y=00001001 -> abc=011
  - y=00010001 -> abc=100
  - y=00100001 -> abc=101
  - y=01000001 -> abc=110
  - y=11000001 -> abc=111
  - d=1 for all.
- Latency check: change y from 8'h01 to 8'h80 just after an edge -> outputs stay abc=000,d=1 until the next edge, then become abc=111,d=1.
- Exhaustive sweep: all 256 y values, each compared one cycle later against a reference model (highest set index, d=|y).
- Reset mid-stream: y=8'h40 gives abc=110,d=1; assert rst_n=0 for one edge -> 0000; deassert -> abc=110,d=1 after the following edge.

Source files
------------

// File: rtl/priority_encoder_pkg.sv
// Shared widths and types for the 8-to-3 priority encoder.
// IN_W is the request vector width and IDX_W is the index width.
package priority_encoder_pkg;

  localparam int IN_W  = 8;
  localparam int IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;

endpackage : priority_encoder_pkg

// File: rtl/priority_encoder_core.sv
// Combinational core: finds the index of the most significant set request bit.
// An all-zero request vector gives index 0 with valid low.
module priority_encoder_core
  import priority_encoder_pkg::*;
(
  input  logic [IN_W-1:0] y,
  output idx_t            idx,
  output logic            valid
);

  idx_t idx_s;
  logic valid_s;

  // casez arms are listed from the highest bit down, so the first match wins
  always_comb begin
    idx_s   = 3'd0;
    valid_s = |y;
    casez (y)
      8'b1???????: idx_s = 3'd7;
      8'b01??????: idx_s = 3'd6;
      8'b001?????: idx_s = 3'd5;
      8'b0001????: idx_s = 3'd4;
      8'b00001???: idx_s = 3'd3;
      8'b000001??: idx_s = 3'd2;
      8'b0000001?: idx_s = 3'd1;
      8'b00000001: idx_s = 3'd0;
      default:     idx_s = 3'd0;
    endcase
  end

  assign idx   = idx_s;
  assign valid = valid_s;

endmodule : priority_encoder_core

// File: rtl/priority_encoder.sv
// 8-input priority encoder. Outputs are {a,b,c} = index and d = valid, and
// they are registered with a synchronous active-low reset when REG_OUT is 1.
module priority_encoder
  import priority_encoder_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] y,
  output logic            a,
  output logic            b,
  output logic            c,
  output logic            d
);

  idx_t idx_s;
  logic valid_s;

  priority_encoder_core u_core (
    .y     (y),
    .idx   (idx_s),
    .valid (valid_s)
  );

  generate
    if (REG_OUT) begin : g_reg
      idx_t idx_r;
      logic valid_r;

      // Output stage: reset is sampled on the clock edge only
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          idx_r   <= 3'd0;
          valid_r <= 1'b0;
        end else begin
          idx_r   <= idx_s;
          valid_r <= valid_s;
        end
      end

      assign {a, b, c} = idx_r;
      assign d         = valid_r;
    end else begin : g_bypass
      assign {a, b, c} = idx_s;
      assign d         = valid_s;
    end
  endgenerate

endmodule : priority_encoder

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder: directed vectors, a latency check,
// a mid-stream reset and a full 256-value sweep against a reference loop.
module tb_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] y;
  logic       a, b, c, d;

  int err_cnt = 0;
  int chk_cnt = 0;

  priority_encoder #(.REG_OUT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .y     (y),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed and expected values are packed as {a,b,c,d}
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got abcd=%b expected abcd=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_model(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) idx = k[2:0];
    end
    return {idx, |v};
  endfunction

  logic [7:0] vec_y   [13];
  logic [3:0] vec_exp [13];

  initial begin
    vec_y[0]  = 8'b00000000; vec_exp[0]  = 4'b0000;
    vec_y[1]  = 8'b00000001; vec_exp[1]  = 4'b0001;
    vec_y[2]  = 8'b00000011; vec_exp[2]  = 4'b0011;
    vec_y[3]  = 8'b00000101; vec_exp[3]  = 4'b0101;
    vec_y[4]  = 8'b00001001; vec_exp[4]  = 4'b0111;
    vec_y[5]  = 8'b00010001; vec_exp[5]  = 4'b1001;
    vec_y[6]  = 8'b00100001; vec_exp[6]  = 4'b1011;
    vec_y[7]  = 8'b01000001; vec_exp[7]  = 4'b1101;
    vec_y[8]  = 8'b11000001; vec_exp[8]  = 4'b1111;
    vec_y[9]  = 8'b10000000; vec_exp[9]  = 4'b1111;
    vec_y[10] = 8'b00000010; vec_exp[10] = 4'b0011;
    vec_y[11] = 8'b00001000; vec_exp[11] = 4'b0111;
    vec_y[12] = 8'b11111111; vec_exp[12] = 4'b1111;

    // Reset held for two edges with every request bit set
    rst_n = 1'b0;
    y     = 8'hFF;
    tick();
    tick();
    check("reset_hold", {a, b, c, d}, 4'b0000);
    rst_n = 1'b1;
    y     = 8'h00;
    tick();
    check("reset_release_y0", {a, b, c, d}, 4'b0000);

    for (int i = 0; i < 13; i++) begin
      y = vec_y[i];
      tick();
      check($sformatf("directed_%0d_y%b", i, vec_y[i]), {a, b, c, d}, vec_exp[i]);
    end

    // Latency: y changes between edges and must not show until the next edge
    y = 8'h01;
    tick();
    check("lat_before", {a, b, c, d}, 4'b0001);
    y = 8'h80;
    #2;
    check("lat_hold", {a, b, c, d}, 4'b0001);
    tick();
    check("lat_after", {a, b, c, d}, 4'b1111);

    // Mid-stream reset, including the synchronous hold before the edge
    y = 8'h40;
    tick();
    check("mid_before_rst", {a, b, c, d}, 4'b1101);
    rst_n = 1'b0;
    #2;
    check("mid_rst_pre_edge", {a, b, c, d}, 4'b1101);
    tick();
    check("mid_rst", {a, b, c, d}, 4'b0000);
    rst_n = 1'b1;
    tick();
    check("mid_rst_release", {a, b, c, d}, 4'b1101);

    for (int v = 0; v < 256; v++) begin
      y = v[7:0];
      tick();
      check($sformatf("sweep_y%02h", v[7:0]), {a, b, c, d}, ref_model(v[7:0]));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_priority_encoder
